fifo_flush_sched: RTL and testbench
===================================

Name: fifo_flush_sched

Overview:
Scheduler that sequences the nibble-FIFO flush port. It decides when to flush, drives the two-cycle flush pulse and the read-valid strobe, and captures the 32-bit flushed word into a one-deep output register with a valid/ready handshake. Flush triggers are FIFO full, data-available, a software force request and an idle timeout. It sits between the nibble FIFO and the downstream word consumer.

Parameters:
TIMEOUT, 64, cycles of non-empty idle before a partial flush; 0 disables the timeout
GAP_CYCLES, 2, cycles of flush-low recovery after each flush; legal range 1..15
CNT_W, 16, width of the flush statistics counter

Ports:
clk  in  1  clock; all logic on rising edge
reset  in  1  asynchronous, active-high reset
enable_i  in  1  allows new flushes to start
force_flush_i  in  1  single-cycle software flush request
fifo_data_avail_i  in  1  FIFO holds at least 4 nibbles
fifo_empty_i  in  1  FIFO empty
fifo_full_i  in  1  FIFO full
fifo_rd_data_i  in  32  flushed word from the FIFO; unused nibbles are 0xC
fifo_flush_o  out  1  flush request to the FIFO
fifo_rd_valid_o  out  1  read strobe and flush-done to the FIFO
out_valid_o  out  1  captured word valid
out_ready_i  in  1  consumer accepts the word
out_data_o  out  32  captured word
flush_reason_o  out  2  reason for the last flush: 0 = full, 1 = avail, 2 = force, 3 = timeout
force_pending_o  out  1  a force request is latched
busy_o  out  1  FSM is not in IDLE
flush_count_o  out  CNT_W  number of completed flushes; saturates at all-ones

Behaviour:
- Reset, asynchronous, active-high:
  - State goes to IDLE.
  - All outputs are 0 and every counter is 0.
  - Applies immediately, even mid-flush; fifo_flush_o drops in the same cycle.
- FSM states: IDLE -> FLUSH1 -> FLUSH2 -> GAP -> IDLE. All outputs come from registers.
- IDLE:
  - A flush starts when enable_i is 1, out_valid_o is 0, and at least one trigger is true.
  - Triggers, in priority order for flush_reason_o:
    - fifo_full_i
    - fifo_data_avail_i
    - force_pending_o with fifo_empty_i = 0
    - the timeout counter has reached TIMEOUT-1 and TIMEOUT != 0
  - flush_reason_o is loaded at the IDLE -> FLUSH1 transition.
- FLUSH1: fifo_flush_o = 1 and fifo_rd_valid_o = 0. The FIFO latches its output word in this cycle.
- FLUSH2:
  - fifo_flush_o = 1 and fifo_rd_valid_o = 1.
  - On the closing edge: out_data_o <= fifo_rd_data_i, out_valid_o <= 1, and flush_count_o increments (saturating).
- GAP:
  - fifo_flush_o = 0 for GAP_CYCLES cycles, counted by a 4-bit counter. This lets the FIFO clear its flush state and re-evaluate data-available.
  - No new flush may start during GAP; the FSM returns to IDLE when the count expires.
- Latency: the decision edge is T. fifo_flush_o is high in cycles T+1 and T+2. fifo_rd_valid_o is high in cycle T+2. out_valid_o rises at T+3. The next flush can start at the earliest in cycle T+3+GAP_CYCLES.
- Output handshake:
  - out_data_o and out_valid_o are held stable until out_valid_o && out_ready_i.
  - out_valid_o clears on the edge after the handshake.
  - A flush is never started while out_valid_o = 1. There is no overwrite and no data loss.
- Force request:
  - force_pending_o is set by force_flush_i in any state.
  - It is cleared on entry to FLUSH1, whatever the flush reason.
  - If force_flush_i and entry to FLUSH1 coincide, pending stays set.
  - If force is pending in IDLE with fifo_empty_i = 1 and enable_i = 1, pending is cleared with no flush.
- Timeout counter:
  - Increments in IDLE while fifo_empty_i = 0.
  - Clears when fifo_empty_i = 1, on entry to FLUSH1, or when TIMEOUT = 0.
  - Holds in other states and saturates at TIMEOUT-1.
  - Width is clog2(TIMEOUT+1).
- enable_i low:
  - Blocks new flush starts only; a sequence already in progress always completes through GAP.
  - Triggers are still evaluated every cycle and a pending force is retained.
- busy_o = 1 in FLUSH1, FLUSH2 and GAP.

Test Plan:
- Bench FIFO model holding nibbles 1,2,3,4 drives fifo_data_avail_i = 1 and fifo_rd_data_i = 0xCCCC4321 at edge T -> fifo_flush_o high at T+1 and T+2, fifo_rd_valid_o high at T+2, out_data_o = 0xCCCC4321 and out_valid_o = 1 at T+3, flush_reason_o = 1, flush_count_o = 1.
- out_ready_i held 0 for 10 cycles with fifo_data_avail_i still 1 -> no second fifo_flush_o pulse and out_data_o stable; after out_ready_i = 1, the next flush starts 1 cycle after out_valid_o clears.
- TIMEOUT = 8, 2 nibbles written, no further writes -> flush starts 8 cycles after the FIFO became non-empty, flush_reason_o = 3, captured word 0xCCCCCC21.
- force_flush_i pulse with fifo_empty_i = 1 -> force_pending_o clears after 1 cycle with no flush. Repeat with 1 nibble present -> flush with flush_reason_o = 2.
- fifo_full_i and fifo_data_avail_i both asserted together with a force pending -> flush_reason_o = 0 and force_pending_o cleared.
- reset asserted during FLUSH2 -> fifo_flush_o, fifo_rd_valid_o and busy_o go to 0 asynchronously, out_valid_o = 0, flush_count_o = 0.

Source files
------------

// File: rtl/fifo_flush_sched.sv
// fifo_flush_sched: sequences the nibble-FIFO flush port and holds the flushed word
// in a one-deep valid/ready output register.
module fifo_flush_sched #(
   parameter int TIMEOUT    = 64,
   parameter int GAP_CYCLES = 2,
   parameter int CNT_W      = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable_i,
   input  logic             force_flush_i,
   input  logic             fifo_data_avail_i,
   input  logic             fifo_empty_i,
   input  logic             fifo_full_i,
   input  logic [31:0]      fifo_rd_data_i,
   output logic             fifo_flush_o,
   output logic             fifo_rd_valid_o,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [31:0]      out_data_o,
   output logic [1:0]       flush_reason_o,
   output logic             force_pending_o,
   output logic             busy_o,
   output logic [CNT_W-1:0] flush_count_o
);
   localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [TW-1:0] TMAX = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;
   localparam logic [3:0] GMAX = 4'(GAP_CYCLES - 1);
   typedef enum logic [1:0] {IDLE, FLUSH1, FLUSH2, GAP} state_t;
   state_t state_q, state_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic [3:0] gap_q, gap_d;
   logic flush_q, flush_d, rdv_q, rdv_d, busy_q, busy_d, ov_q, ov_d, force_q, force_d;
   logic [31:0] data_q, data_d;
   logic [1:0] reason_q, reason_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic idle, force_ok, tmo_hit, trig, start;
   always_comb begin
      idle = state_q == IDLE;
      force_ok = force_q & ~fifo_empty_i;
      tmo_hit = (TIMEOUT != 0) && (tmo_q == TMAX);
      trig = fifo_full_i | fifo_data_avail_i | force_ok | tmo_hit;
      start = idle & enable_i & ~ov_q & trig;
      state_d = start ? FLUSH1 :
                state_q == FLUSH1 ? FLUSH2 :
                state_q == FLUSH2 ? GAP :
                (state_q == GAP && gap_q == GMAX) ? IDLE : state_q;
      gap_d = (state_q == GAP) ? gap_q + 4'd1 : 4'd0;
      flush_d = state_d == FLUSH1 || state_d == FLUSH2;
      rdv_d = state_d == FLUSH2;
      busy_d = state_d != IDLE;
      reason_d = !start ? reason_q : fifo_full_i ? 2'd0 : fifo_data_avail_i ? 2'd1 : force_ok ? 2'd2 : 2'd3;
      // a new request on the flush-entry edge survives for the next flush
      force_d = force_flush_i | (force_q & ~start & ~(idle & fifo_empty_i & enable_i));
      tmo_d = (TIMEOUT == 0 || fifo_empty_i || start) ? '0 : (idle && !tmo_hit) ? tmo_q + 1'b1 : tmo_q;
      data_d = (state_q == FLUSH2) ? fifo_rd_data_i : data_q;
      ov_d = (state_q == FLUSH2) ? 1'b1 : (ov_q & out_ready_i) ? 1'b0 : ov_q;
      cnt_d = (state_q == FLUSH2 && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         tmo_q    <= '0;
         gap_q    <= '0;
         flush_q  <= 1'b0;
         rdv_q    <= 1'b0;
         busy_q   <= 1'b0;
         ov_q     <= 1'b0;
         force_q  <= 1'b0;
         data_q   <= '0;
         reason_q <= '0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         tmo_q    <= tmo_d;
         gap_q    <= gap_d;
         flush_q  <= flush_d;
         rdv_q    <= rdv_d;
         busy_q   <= busy_d;
         ov_q     <= ov_d;
         force_q  <= force_d;
         data_q   <= data_d;
         reason_q <= reason_d;
         cnt_q    <= cnt_d;
      end
   end
   assign fifo_flush_o    = flush_q;
   assign fifo_rd_valid_o = rdv_q;
   assign out_valid_o     = ov_q;
   assign out_data_o      = data_q;
   assign flush_reason_o  = reason_q;
   assign force_pending_o = force_q;
   assign busy_o          = busy_q;
   assign flush_count_o   = cnt_q;
endmodule

// File: tb/tb_fifo_flush_sched.sv
// tb_fifo_flush_sched: directed bench with a small nibble-FIFO model feeding the scheduler.
module tb_fifo_flush_sched;
   logic clk = 1'b0;
   logic reset = 1'b1;
   logic enable_i = 1'b1;
   logic force_flush_i = 1'b0;
   logic fifo_data_avail_i, fifo_empty_i, fifo_full_i;
   logic [31:0] fifo_rd_data_i;
   logic fifo_flush_o, fifo_rd_valid_o, out_valid_o;
   logic out_ready_i = 1'b0;
   logic [31:0] out_data_o;
   logic [1:0] flush_reason_o;
   logic force_pending_o, busy_o;
   logic [15:0] flush_count_o;
   logic [3:0] fq[$];
   int vectors = 0;
   int errs = 0;
   always #5 clk = ~clk;
   fifo_flush_sched #(.TIMEOUT(8), .GAP_CYCLES(2), .CNT_W(16)) dut (
      .clk(clk), .reset(reset), .enable_i(enable_i), .force_flush_i(force_flush_i),
      .fifo_data_avail_i(fifo_data_avail_i), .fifo_empty_i(fifo_empty_i), .fifo_full_i(fifo_full_i),
      .fifo_rd_data_i(fifo_rd_data_i), .fifo_flush_o(fifo_flush_o), .fifo_rd_valid_o(fifo_rd_valid_o),
      .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_data_o(out_data_o),
      .flush_reason_o(flush_reason_o), .force_pending_o(force_pending_o), .busy_o(busy_o),
      .flush_count_o(flush_count_o)
   );
   task automatic upd();
      fifo_empty_i = fq.size() == 0;
      fifo_data_avail_i = fq.size() >= 4;
      fifo_full_i = fq.size() >= 8;
      for (int i = 0; i < 8; i++)
         fifo_rd_data_i[4*i +: 4] = (i < fq.size()) ? fq[i] : 4'hC;
   endtask
   task automatic push(input logic [3:0] n);
      fq.push_back(n);
      upd();
   endtask
   // inputs change 1 time unit after the edge; a read strobe seen now drains the FIFO at the next edge
   task automatic step();
      logic rv;
      rv = fifo_rd_valid_o;
      @(posedge clk);
      #1;
      if (rv)
         for (int i = 0; i < 8 && fq.size() > 0; i++)
            void'(fq.pop_front());
      upd();
   endtask
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      assert (got === exp) else begin
         errs++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask
   initial begin
      upd();
      step();
      step();
      chk("rst_flush", 32'(fifo_flush_o), 0);
      chk("rst_rdv", 32'(fifo_rd_valid_o), 0);
      chk("rst_ov", 32'(out_valid_o), 0);
      chk("rst_busy", 32'(busy_o), 0);
      chk("rst_cnt", 32'(flush_count_o), 0);
      chk("rst_data", out_data_o, 0);
      chk("rst_pend", 32'(force_pending_o), 0);
      reset = 1'b0;
      step();
      // avail flush: nibbles 1..4
      push(1); push(2); push(3); push(4);
      step();
      chk("t1_flush1", 32'(fifo_flush_o), 1);
      chk("t1_rdv1", 32'(fifo_rd_valid_o), 0);
      chk("t1_busy", 32'(busy_o), 1);
      step();
      chk("t1_flush2", 32'(fifo_flush_o), 1);
      chk("t1_rdv2", 32'(fifo_rd_valid_o), 1);
      step();
      chk("t1_flush3", 32'(fifo_flush_o), 0);
      chk("t1_ov", 32'(out_valid_o), 1);
      chk("t1_data", out_data_o, 32'hCCCC4321);
      chk("t1_reason", 32'(flush_reason_o), 1);
      chk("t1_cnt", 32'(flush_count_o), 1);
      // backpressure: data available but output register full
      push(1); push(2); push(3); push(4);
      for (int i = 0; i < 10; i++) begin
         step();
         chk("bp_noflush", 32'(fifo_flush_o), 0);
         chk("bp_data", out_data_o, 32'hCCCC4321);
      end
      out_ready_i = 1'b1;
      step();
      out_ready_i = 1'b0;
      chk("bp_ovclr", 32'(out_valid_o), 0);
      chk("bp_flush_lo", 32'(fifo_flush_o), 0);
      step();
      chk("bp_flush_hi", 32'(fifo_flush_o), 1);
      step();
      step();
      chk("bp_ov2", 32'(out_valid_o), 1);
      chk("bp_cnt", 32'(flush_count_o), 2);
      out_ready_i = 1'b1;
      step();
      out_ready_i = 1'b0;
      step(); step(); step();
      // timeout flush with two nibbles
      push(1); push(2);
      for (int i = 0; i < 7; i++) begin
         step();
         chk("to_wait", 32'(fifo_flush_o), 0);
      end
      step();
      chk("to_flush", 32'(fifo_flush_o), 1);
      step();
      step();
      chk("to_ov", 32'(out_valid_o), 1);
      chk("to_data", out_data_o, 32'hCCCCCC21);
      chk("to_reason", 32'(flush_reason_o), 3);
      chk("to_cnt", 32'(flush_count_o), 3);
      out_ready_i = 1'b1;
      step();
      out_ready_i = 1'b0;
      step(); step(); step();
      // force with empty FIFO drops the request
      force_flush_i = 1'b1;
      step();
      force_flush_i = 1'b0;
      chk("fe_pend1", 32'(force_pending_o), 1);
      step();
      chk("fe_pend0", 32'(force_pending_o), 0);
      chk("fe_busy", 32'(busy_o), 0);
      step();
      chk("fe_noflush", 32'(fifo_flush_o), 0);
      // force with one nibble
      push(5);
      force_flush_i = 1'b1;
      step();
      force_flush_i = 1'b0;
      chk("f1_pend", 32'(force_pending_o), 1);
      chk("f1_noflush", 32'(fifo_flush_o), 0);
      step();
      chk("f1_flush", 32'(fifo_flush_o), 1);
      chk("f1_pendclr", 32'(force_pending_o), 0);
      step();
      step();
      chk("f1_data", out_data_o, 32'hCCCCCCC5);
      chk("f1_reason", 32'(flush_reason_o), 2);
      chk("f1_cnt", 32'(flush_count_o), 4);
      out_ready_i = 1'b1;
      step();
      out_ready_i = 1'b0;
      step(); step(); step();
      // full + avail + pending force, held off by enable low
      enable_i = 1'b0;
      force_flush_i = 1'b1;
      for (int i = 1; i <= 8; i++) push(4'(i));
      step();
      force_flush_i = 1'b0;
      step();
      chk("fu_hold", 32'(fifo_flush_o), 0);
      chk("fu_pend", 32'(force_pending_o), 1);
      enable_i = 1'b1;
      step();
      chk("fu_flush", 32'(fifo_flush_o), 1);
      chk("fu_pendclr", 32'(force_pending_o), 0);
      chk("fu_reason", 32'(flush_reason_o), 0);
      step();
      step();
      chk("fu_data", out_data_o, 32'h87654321);
      chk("fu_cnt", 32'(flush_count_o), 5);
      out_ready_i = 1'b1;
      step();
      out_ready_i = 1'b0;
      step(); step(); step();
      // asynchronous reset in FLUSH2
      push(1); push(2); push(3); push(4);
      step();
      step();
      chk("ar_rdv", 32'(fifo_rd_valid_o), 1);
      #2;
      reset = 1'b1;
      #1;
      chk("ar_flush", 32'(fifo_flush_o), 0);
      chk("ar_rdv0", 32'(fifo_rd_valid_o), 0);
      chk("ar_busy", 32'(busy_o), 0);
      chk("ar_ov", 32'(out_valid_o), 0);
      chk("ar_cnt", 32'(flush_count_o), 0);
      step();
      reset = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end
endmodule
